board_ram_scheduler: RTL and testbench
======================================

# board_ram_scheduler

Owns the single-port board-status RAM: 10x10 cells, 5-bit status, 1-cycle synchronous read. It shares the RAM between two requesters. The VGA pixel path gets hard-deadline prefetch slots, so `cell_status_out` is valid for every 64x48 cell the driver is painting. The game logic (placement, player/IA shots) gets the remaining cycles through a req/ack handshake with hardware read-modify-write hit merging. It sits between the VGA timing generator, the game FSM, the board RAM and the VGA colour driver.

## Interface
- `H_CELL`, 64: pixels per cell horizontally; a power of two.
- `V_CELL`, 48: lines per cell vertically.
- `N_COLS`, 10: board columns.
- `N_ROWS`, 10: board rows.
- `LEAD`, 2: cycles before a cell boundary at which the VGA read is issued; must be at least 2.
- `clk_in`  in  1  pixel clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `pix_x_in`  in  10  current pixel column.
- `pix_y_in`  in  10  current pixel line.
- `pix_valid_in`  in  1  high in the visible area.
- `cell_status_out`  out  5  status of the cell under `pix_x_in`/`pix_y_in`, to the colour driver.
- `req_in`  in  1  game request; held until `ack_out`.
- `req_op_in`  in  2  operation code:
  - 00: read.
  - 01: write `req_wdata_in`.
  - 10: player hit.
  - 11: IA hit.
- `req_x_in`, `req_y_in`  in  4 each  target cell.
- `req_wdata_in`  in  5  write data.
- `ack_out`  out  1  one-cycle completion pulse.
- `rdata_out`  out  5  pre-op cell status; valid with `ack_out`.
- `err_out`  out  1  coordinates out of range; valid with `ack_out`.
- `ram_addr_out`  out  7  RAM address, y*N_COLS+x.
- `ram_we_out`  out  1  RAM write enable.
- `ram_wdata_out`  out  5  RAM write data.
- `ram_rdata_in`  in  5  RAM read data, one cycle after the address.

## Operation
- **VGA tracker.**
  - `band_y` (0..N_ROWS-1) and `sub_y` (0..V_CELL-1) advance on every `pix_valid_in` falling edge.
  - `sub_y` wraps at V_CELL-1 and increments `band_y`; `band_y` wraps N_ROWS-1 to 0.
  - Resync: a `pix_valid_in` rising edge with `pix_y_in`==0 forces `band_y`=`sub_y`=0.
  - Cell x is `pix_x_in`/H_CELL, taken from the top bits.
- **VGA slots.**
  - Mid-line: a read of cell (x+1, band) is issued when `pix_valid_in`=1, `pix_x_in` mod H_CELL = H_CELL-LEAD and x+1 < N_COLS.
  - Line start: a read of (0, next band) is issued the cycle after the `pix_valid_in` fall. The next band is computed with the same wrap rules as the tracker.
  - Data is captured into `pf_reg` one cycle after issue.
  - `pf_reg` is copied to `cell_status_out` on the edge where `pix_x_in` mod H_CELL = H_CELL-1, or where `pix_valid_in` rises.
- **Priority.** A VGA slot always owns the RAM. A game access scheduled for that cycle stalls one cycle; FSM state and latched request fields are held.
- **Game FSM** (IDLE, G_RD, G_CAP, G_WR, G_ACK):
  - IDLE: on `req_in` with x and y both < 10, latch op/x/y/wdata and go to G_RD.
  - IDLE, out of range: go directly to G_ACK with `err_out`=1; no RAM access.
  - G_RD: drive the address with `ram_we_out`=0.
  - G_CAP: capture `ram_rdata_in` into `rdata_out`. Op 00 goes to G_ACK; all other ops go to G_WR.
  - G_WR: assert `ram_we_out` with new data.
    - Op 01 writes `req_wdata_in`.
    - Ops 10/11 write the merge result.
  - G_ACK: pulse `ack_out`, return to IDLE. A new request is accepted no earlier than the cycle after `ack_out`.
- **Hit merge.** Status codes: free=0, occ=1, player_hit=2, ia_hit=3, both=4.
  - Player hit: 0/1 becomes 2; 3 becomes 4; 2 and 4 are unchanged.
  - IA hit: 0/1 becomes 3; 2 becomes 4; 3 and 4 are unchanged.
  - Codes above 4 are written back unchanged.
- **Self-collision.** A game write to the cell currently held in `pf_reg` does not update `pf_reg`. The new value appears on the cell's next fetch.

## Timing
- **Reset.** Every output is 0 and the FSM is IDLE. The tracker, `pf_reg` and `cell_status_out` are also 0. Reset is effective immediately, including mid-transaction.
- **Reset mid-transaction.** A pending write is dropped: `ram_we_out` is forced to 0 asynchronously. The requester must re-issue.
- **Game latency** from a `req_in` sample in IDLE to `ack_out`, with no stall:
  - Read: 3 cycles.
  - Write and hit ops: 4 cycles.
  - Error: 1 cycle.
  - Each VGA slot collision adds 1 cycle.
- **VGA read.** Issued LEAD cycles before the boundary; the status is visible on the first pixel of the cell.

## Structure
- Shared package `board_pkg`:
  - Status codes free/occ/player_hit/ia_hit/both.
  - Op codes.
  - N_COLS/N_ROWS/H_CELL/V_CELL defaults.
  - Address width.
- One sub-module, `board_cell_tracker`: band/sub-line counters, resync, and generation of the VGA slot strobe plus address. The FSM and merge stay in the top module.

## Test plan
- **Frame walk.** RAM preloaded with status = (x+y) mod 5; a full 640x480 frame is driven. Required: `cell_status_out` matches the cell under every valid pixel, e.g. (x=130, y=100) gives 4.
- **Player hit on occupied cell.** Op 10 on (3,4) holding 1, away from VGA slots. Required: `ack_out` 4 cycles after `req_in`, `rdata_out`=1, RAM[43]=2.
- **Merge to both.** Op 11 on a cell holding 2. Required: cell becomes 4. A repeated op 11 leaves it at 4.
- **Slot collision.** Game G_RD placed on the cycle with `pix_x_in`=126. Required: the VGA read of cell 2 wins, the game read is deferred, and `ack_out` arrives at 4 cycles for a read.
- **Out of range.** Request with x=10. Required: `ack_out` next cycle, `err_out`=1, no `ram_we_out` assertion.
- **Reset during G_WR.** Required: `ram_we_out` drops immediately, the RAM cell is unchanged, all outputs are 0, and the FSM is IDLE.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for the board-status RAM scheduler: status codes,
// game op codes, board geometry defaults and the hit-merge rule.
package board_pkg;

  localparam int ST_W   = 5;
  localparam int ADDR_W = 7;

  localparam int DEF_H_CELL = 64;
  localparam int DEF_V_CELL = 48;
  localparam int DEF_N_COLS = 10;
  localparam int DEF_N_ROWS = 10;
  localparam int DEF_LEAD   = 2;

  localparam logic [ST_W-1:0] ST_FREE  = 5'd0;
  localparam logic [ST_W-1:0] ST_OCC   = 5'd1;
  localparam logic [ST_W-1:0] ST_PHIT  = 5'd2;
  localparam logic [ST_W-1:0] ST_IAHIT = 5'd3;
  localparam logic [ST_W-1:0] ST_BOTH  = 5'd4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PHIT  = 2'b10;
  localparam logic [1:0] OP_IAHIT = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    G_RD  = 3'd1,
    G_CAP = 3'd2,
    G_WR  = 3'd3,
    G_ACK = 3'd4
  } game_state_e;

  // Codes above ST_BOTH are not hit states and fall through unchanged.
  function automatic logic [ST_W-1:0] hit_merge(input logic [1:0] op,
                                                input logic [ST_W-1:0] cur);
    logic [ST_W-1:0] res;
    res = cur;
    if (op == OP_PHIT) begin
      if (cur == ST_FREE || cur == ST_OCC) res = ST_PHIT;
      else if (cur == ST_IAHIT)            res = ST_BOTH;
    end else if (op == OP_IAHIT) begin
      if (cur == ST_FREE || cur == ST_OCC) res = ST_IAHIT;
      else if (cur == ST_PHIT)             res = ST_BOTH;
    end
    return res;
  endfunction

endpackage

// File: rtl/board_cell_tracker.sv
// Follows the raster in cell units and raises the VGA prefetch slot (with its
// RAM address) plus the strobe that moves prefetched data to the colour driver.
module board_cell_tracker
  import board_pkg::*;
#(
  parameter int H_CELL = DEF_H_CELL,
  parameter int V_CELL = DEF_V_CELL,
  parameter int N_COLS = DEF_N_COLS,
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int LEAD   = DEF_LEAD
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [9:0]        pix_x_in,
  input  logic [9:0]        pix_y_in,
  input  logic              pix_valid_in,
  output logic              slot_out,
  output logic [ADDR_W-1:0] slot_addr_out,
  output logic              copy_out
);

  localparam int XS = $clog2(H_CELL);
  localparam int BW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int SW = (V_CELL > 1) ? $clog2(V_CELL) : 1;

  logic          valid_q, valid_d;
  logic          fall_q, fall_d;
  logic [BW-1:0] band_q, band_d;
  logic [SW-1:0] sub_q, sub_d;
  logic          rise, fall, mid_slot;
  logic [9:0]    cell_x;
  logic [XS-1:0] x_mod;

  always_comb begin
    cell_x  = pix_x_in >> XS;
    x_mod   = pix_x_in[XS-1:0];
    rise    = pix_valid_in & ~valid_q;
    fall    = ~pix_valid_in & valid_q;
    valid_d = pix_valid_in;
    fall_d  = fall;
    band_d  = band_q;
    sub_d   = sub_q;
    if (rise && pix_y_in == '0) begin
      band_d = '0;
      sub_d  = '0;
    end else if (fall) begin
      if (sub_q == SW'(V_CELL - 1)) begin
        sub_d  = '0;
        band_d = (band_q == BW'(N_ROWS - 1)) ? '0 : band_q + BW'(1);
      end else begin
        sub_d = sub_q + SW'(1);
      end
    end
    // Mid-line slot fetches the next cell; the registered fall is the line-start
    // slot, issued after band_q has already moved to the coming line's band.
    mid_slot = rst_n_in & pix_valid_in & (x_mod == XS'(H_CELL - LEAD))
             & ((cell_x + 10'd1) < 10'(N_COLS));
    slot_out      = mid_slot | fall_q;
    slot_addr_out = ADDR_W'(band_q) * ADDR_W'(N_COLS);
    if (mid_slot) slot_addr_out = slot_addr_out + ADDR_W'(cell_x + 10'd1);
    copy_out = (x_mod == XS'(H_CELL - 1)) | rise;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= 1'b0;
      fall_q  <= 1'b0;
      band_q  <= '0;
      sub_q   <= '0;
    end else begin
      valid_q <= valid_d;
      fall_q  <= fall_d;
      band_q  <= band_d;
      sub_q   <= sub_d;
    end
  end

endmodule

// File: rtl/board_ram_scheduler.sv
// Arbitrates the single-port board RAM between hard-deadline VGA prefetch slots
// and game read/write/hit requests with read-modify-write hit merging.
module board_ram_scheduler
  import board_pkg::*;
#(
  parameter int H_CELL = DEF_H_CELL,
  parameter int V_CELL = DEF_V_CELL,
  parameter int N_COLS = DEF_N_COLS,
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int LEAD   = DEF_LEAD
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [9:0]        pix_x_in,
  input  logic [9:0]        pix_y_in,
  input  logic              pix_valid_in,
  output logic [ST_W-1:0]   cell_status_out,
  input  logic              req_in,
  input  logic [1:0]        req_op_in,
  input  logic [3:0]        req_x_in,
  input  logic [3:0]        req_y_in,
  input  logic [ST_W-1:0]   req_wdata_in,
  output logic              ack_out,
  output logic [ST_W-1:0]   rdata_out,
  output logic              err_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_we_out,
  output logic [ST_W-1:0]   ram_wdata_out,
  input  logic [ST_W-1:0]   ram_rdata_in,
  output logic [2:0]        dbg_state_out
);

  // Game handshake: req_in and its fields are held from assertion until the
  // single-cycle ack_out; rdata_out/err_out are valid in the ack cycle and the
  // next request is only sampled in IDLE, i.e. the cycle after ack_out.

  game_state_e       state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ST_W-1:0]   wdata_q, wdata_d;
  logic [ST_W-1:0]   rdata_q, rdata_d;
  logic [ST_W-1:0]   pf_q, pf_d;
  logic [ST_W-1:0]   cso_q, cso_d;
  logic              err_q, err_d;
  logic              slot_q, slot_d;
  logic              slot, copy, in_range;
  logic [ADDR_W-1:0] slot_addr;

  board_cell_tracker #(
    .H_CELL(H_CELL), .V_CELL(V_CELL), .N_COLS(N_COLS), .N_ROWS(N_ROWS), .LEAD(LEAD)
  ) u_tracker (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .pix_x_in     (pix_x_in),
    .pix_y_in     (pix_y_in),
    .pix_valid_in (pix_valid_in),
    .slot_out     (slot),
    .slot_addr_out(slot_addr),
    .copy_out     (copy)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    slot_d   = slot;
    // Forwarding pf_d lets LEAD=2 data reach the output on the boundary edge.
    pf_d     = slot_q ? ram_rdata_in : pf_q;
    cso_d    = copy ? pf_d : cso_q;
    in_range = ({1'b0, req_x_in} < 5'(N_COLS)) && ({1'b0, req_y_in} < 5'(N_ROWS));
    case (state_q)
      IDLE: begin
        if (req_in) begin
          if (in_range) begin
            op_d    = req_op_in;
            addr_d  = ADDR_W'(req_y_in) * ADDR_W'(N_COLS) + ADDR_W'(req_x_in);
            wdata_d = req_wdata_in;
            err_d   = 1'b0;
            state_d = G_RD;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = G_ACK;
          end
        end
      end
      G_RD:  if (!slot) state_d = G_CAP;
      G_CAP: begin
        rdata_d = ram_rdata_in;
        if (op_q == OP_READ) begin
          state_d = G_ACK;
        end else begin
          if (op_q != OP_WRITE) wdata_d = hit_merge(op_q, ram_rdata_in);
          state_d = G_WR;
        end
      end
      G_WR:    if (!slot) state_d = G_ACK;
      G_ACK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      slot_q  <= 1'b0;
      pf_q    <= '0;
      cso_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      slot_q  <= slot_d;
      pf_q    <= pf_d;
      cso_q   <= cso_d;
    end
  end

  // Write enable decodes the async-reset state register, so reset kills it at once.
  assign ram_addr_out    = slot ? slot_addr : addr_q;
  assign ram_we_out      = (state_q == G_WR) && !slot;
  assign ram_wdata_out   = (state_q == G_WR) ? wdata_q : '0;
  assign ack_out         = (state_q == G_ACK);
  assign rdata_out       = rdata_q;
  assign err_out         = err_q;
  assign cell_status_out = cso_q;
  assign dbg_state_out   = state_q;

endmodule

// File: tb/tb_board_ram_scheduler.sv
// Randomized game traffic against a board model, a raster walk over a full
// frame, slot collision, out-of-range and reset-during-write scenarios.
module tb_board_ram_scheduler;
  import board_pkg::*;

  localparam int H      = 64;
  localparam int V      = 4;
  localparam int NC     = 10;
  localparam int NR     = 10;
  localparam int NLINES = V * NR;
  localparam int HBLANK = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid;
  logic [4:0] cso;
  logic       req;
  logic [1:0] req_op;
  logic [3:0] req_x, req_y;
  logic [4:0] req_wdata;
  logic       ack;
  logic [4:0] rdata;
  logic       err;
  logic [6:0] ram_addr;
  logic       ram_we;
  logic [4:0] ram_wdata;
  logic [4:0] ram_rdata;
  logic [2:0] dbg_state;

  logic [4:0] mem [0:127];
  logic [4:0] exp_board [0:99];
  int n_vec = 0;
  int n_err = 0;
  int we_seen = 0;

  board_ram_scheduler #(.H_CELL(H), .V_CELL(V), .N_COLS(NC), .N_ROWS(NR), .LEAD(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pix_x_in(pix_x), .pix_y_in(pix_y),
    .pix_valid_in(pix_valid), .cell_status_out(cso), .req_in(req), .req_op_in(req_op),
    .req_x_in(req_x), .req_y_in(req_y), .req_wdata_in(req_wdata), .ack_out(ack),
    .rdata_out(rdata), .err_out(err), .ram_addr_out(ram_addr), .ram_we_out(ram_we),
    .ram_wdata_out(ram_wdata), .ram_rdata_in(ram_rdata), .dbg_state_out(dbg_state)
  );

  always #5 clk = ~clk;

  // Board RAM: synchronous, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) if (ram_we === 1'b1) we_seen <= we_seen + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a cell is a set of hit flags; codes above 4 are opaque.
  function automatic logic [4:0] ref_next(input logic [1:0] op, input logic [4:0] cur,
                                          input logic [4:0] wd);
    bit p, a;
    if (op == 2'b00) return cur;
    if (op == 2'b01) return wd;
    if (cur > 5'd4) return cur;
    p = (cur == 5'd2) || (cur == 5'd4) || (op == 2'b10);
    a = (cur == 5'd3) || (cur == 5'd4) || (op == 2'b11);
    if (p && a) return 5'd4;
    return p ? 5'd2 : 5'd3;
  endfunction

  task automatic game_op(input logic [1:0] op, input int x, input int y, input logic [4:0] wd,
                         output int lat, output logic [4:0] rd, output logic er, output int wes);
    int we0;
    bit got;
    @(posedge clk); #1;
    req = 1'b1; req_op = op; req_x = 4'(x); req_y = 4'(y); req_wdata = wd;
    we0 = we_seen;
    got = 1'b0;
    lat = 20;
    rd = '0;
    er = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = n; rd = rdata; er = err; got = 1'b1;
        break;
      end
    end
    check_eq("ack_seen", 32'(got), 1);
    @(posedge clk); #1;
    req = 1'b0;
    wes = we_seen - we0;
  endtask

  task automatic vga_line(input int y, input bit collide);
    int ack_x;
    int band;
    ack_x = -1;
    band = (y / V) % NR;
    for (int x = 0; x < 640 + HBLANK; x++) begin
      @(posedge clk); #1;
      pix_x = 10'(x); pix_y = 10'(y); pix_valid = (x < 640);
      if (collide && x == 125) begin
        req = 1'b1; req_op = OP_READ; req_x = 4'd6; req_y = 4'd5;
      end
      if (collide && ack_x >= 0 && x == ack_x + 1) req = 1'b0;
      @(negedge clk);
      if (x < 640) check_eq("cso", 32'(cso), 32'(exp_board[band * NC + x / H]));
      if (collide && x == 126) begin
        check_eq("slot_addr", 32'(ram_addr), band * NC + 2);
        check_eq("slot_we", 32'(ram_we), 0);
      end
      if (collide && req && ack === 1'b1) begin
        ack_x = x;
        check_eq("coll_lat", x - 125, 4);
        check_eq("coll_rdata", 32'(rdata), 32'(exp_board[56]));
      end
    end
    if (collide) check_eq("coll_ack_seen", 32'(ack_x >= 0), 1);
    req = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wes, x, y, a;
    logic [1:0] op;
    logic [4:0] rd, wd;
    logic er;

    rst_n = 1'b0; pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    req = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_wdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cso", 32'(cso), 0);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_rdata", 32'(rdata), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_addr", 32'(ram_addr), 0);
    check_eq("rst_we", 32'(ram_we), 0);
    check_eq("rst_wdata", 32'(ram_wdata), 0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Random game traffic with the raster idle.
    for (int i = 0; i < 100; i++) begin
      mem[i] = 5'($urandom_range(0, 7));
      exp_board[i] = mem[i];
    end
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      y  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      wd = 5'($urandom_range(0, 31));
      game_op(op, x, y, wd, lat, rd, er, wes);
      if (x > 9 || y > 9) begin
        check_eq("oor_lat", lat, 1);
        check_eq("oor_err", 32'(er), 1);
        check_eq("oor_we", wes, 0);
      end else begin
        a = y * NC + x;
        check_eq("op_lat", lat, (op == OP_READ) ? 3 : 4);
        check_eq("op_rdata", 32'(rd), 32'(exp_board[a]));
        check_eq("op_err", 32'(er), 0);
        check_eq("op_we", wes, (op == OP_READ) ? 0 : 1);
        exp_board[a] = ref_next(op, exp_board[a], wd);
      end
    end
    for (int i = 0; i < 100; i++) check_eq("ram_cell", 32'(mem[i]), 32'(exp_board[i]));

    // Player hit on occupied (3,4), then IA hit to both, then repeat.
    mem[43] = 5'd1; exp_board[43] = 5'd1;
    game_op(OP_PHIT, 3, 4, 5'd0, lat, rd, er, wes);
    check_eq("phit_lat", lat, 4);
    check_eq("phit_rdata", 32'(rd), 1);
    check_eq("phit_ram", 32'(mem[43]), 32'(ref_next(OP_PHIT, 5'd1, 5'd0)));
    game_op(OP_IAHIT, 3, 4, 5'd0, lat, rd, er, wes);
    check_eq("both_rdata", 32'(rd), 2);
    check_eq("both_ram", 32'(mem[43]), 4);
    game_op(OP_IAHIT, 3, 4, 5'd0, lat, rd, er, wes);
    check_eq("both2_rdata", 32'(rd), 4);
    check_eq("both2_ram", 32'(mem[43]), 4);
    game_op(OP_WRITE, 10, 0, 5'd9, lat, rd, er, wes);
    check_eq("x10_lat", lat, 1);
    check_eq("x10_err", 32'(er), 1);
    check_eq("x10_we", wes, 0);

    // Frame walk plus the start of the next frame; line 4 hosts the collision.
    for (int i = 0; i < 100; i++) begin
      exp_board[i] = 5'(((i % NC) + (i / NC)) % 5);
      mem[i] = exp_board[i];
    end
    for (int ln = 0; ln < NLINES; ln++) vga_line(ln, 1'b0);
    for (int ln = 0; ln < 5; ln++) vga_line(ln, ln == 4);
    @(posedge clk); #1;
    pix_x = '0; pix_y = '0; pix_valid = 1'b0;

    // Reset while the write is on the RAM port.
    @(posedge clk); #1;
    req = 1'b1; req_op = OP_WRITE; req_x = 4'd2; req_y = 4'd2; req_wdata = 5'd7;
    repeat (4) @(negedge clk);
    check_eq("wr_we_pre", 32'(ram_we), 1);
    #1 rst_n = 1'b0; req = 1'b0;
    #1;
    check_eq("rwr_we", 32'(ram_we), 0);
    check_eq("rwr_ack", 32'(ack), 0);
    check_eq("rwr_rdata", 32'(rdata), 0);
    check_eq("rwr_err", 32'(err), 0);
    check_eq("rwr_cso", 32'(cso), 0);
    check_eq("rwr_addr", 32'(ram_addr), 0);
    check_eq("rwr_wdata", 32'(ram_wdata), 0);
    check_eq("rwr_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    check_eq("rwr_ram", 32'(mem[22]), 32'(exp_board[22]));
    rst_n = 1'b1;
    game_op(OP_READ, 2, 2, 5'd0, lat, rd, er, wes);
    check_eq("post_rst_lat", lat, 3);
    check_eq("post_rst_rdata", 32'(rd), 32'(exp_board[22]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
